// File: rtl/axi_read_arbiter_pkg.sv
// axi_read_arbiter_pkg: AXI read channel types, source indices and FSM states for the read arbiter
package axi_read_arbiter_pkg;
   localparam int AXI_ID_W   = 4;
   localparam int AXI_ADDR_W = 32;
   localparam int AXI_DATA_W = 64;
   localparam logic ARB_SRC_ICACHE = 1'b0;
   localparam logic ARB_SRC_DCACHE = 1'b1;
   typedef enum logic {IDLE, LOCK} ArbState;
   typedef struct packed {
      logic                  valid;
      logic [AXI_ID_W-1:0]   id;
      logic [AXI_ADDR_W-1:0] addr;
      logic [7:0]            len;
      logic [2:0]            size;
      logic [1:0]            burst;
   } AxiMAR;
   typedef struct packed {
      logic ready;
   } AxiSAR;
   typedef struct packed {
      logic ready;
   } AxiMR;
   typedef struct packed {
      logic                  valid;
      logic [AXI_ID_W-1:0]   id;
      logic [AXI_DATA_W-1:0] data;
      logic [1:0]            resp;
      logic                  last;
   } AxiSR;
   function automatic logic [AXI_ID_W-1:0] tag_id(input logic src, input logic [AXI_ID_W-1:0] id);
      return {src, id[AXI_ID_W-2:0]};
   endfunction
endpackage

// File: rtl/axi_read_arbiter_outstanding_ctr.sv
// outstanding_ctr: saturating up/down count of accepted-but-unfinished bursts for one source
module outstanding_ctr
   import axi_read_arbiter_pkg::*;
#(
   parameter int MAX = 4,
   parameter int W   = $clog2(MAX + 1)
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         i_inc,
   input  logic         i_dec,
   output logic [W-1:0] o_cnt,
   output logic         o_full,
   output logic         o_underflow
);
   logic [W-1:0] r_cnt;
   // count up on AR accept, down on last R beat; coincident events cancel, both ends saturate
   always_ff @(posedge clk)
      if (rst) r_cnt <= '0;
      else if (i_inc && !i_dec && !o_full) r_cnt <= r_cnt + 1'b1;
      else if (i_dec && !i_inc && r_cnt != '0) r_cnt <= r_cnt - 1'b1;
   assign o_cnt       = r_cnt;
   assign o_full      = r_cnt == W'(MAX);
   assign o_underflow = i_dec && r_cnt == '0;
endmodule

// File: rtl/axi_read_arbiter.sv
// axi_read_arbiter: round-robin sharing of one AXI read channel between ICache and DCache; AXI_RD_ARB_PERF_EN adds perf counters
module axi_read_arbiter
   import axi_read_arbiter_pkg::*;
#(
   parameter int ID_WIDTH        = AXI_ID_W,
   parameter int MAX_OUTSTANDING = 4
) (
   input  logic  clk,
   input  logic  rst,
   input  AxiMAR i_icache_mar,
   output AxiSAR o_icache_sar,
   input  AxiMR  i_icache_mr,
   output AxiSR  o_icache_sr,
   input  AxiMAR i_dcache_mar,
   output AxiSAR o_dcache_sar,
   input  AxiMR  i_dcache_mr,
   output AxiSR  o_dcache_sr,
`ifdef AXI_RD_ARB_PERF_EN
   output logic [31:0] o_perf_grant_icache,
   output logic [31:0] o_perf_grant_dcache,
   output logic [31:0] o_perf_ar_stall,
`endif
   output AxiMAR o_mem_mar,
   input  AxiSAR i_mem_sar,
   output AxiMR  o_mem_mr,
   input  AxiSR  i_mem_sr
);
   localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
   AxiMAR            w_mar [2];
   AxiMR             w_mr [2];
   logic [CNT_W-1:0] w_cnt [2];
   ArbState          r_state, w_state_nx;
   logic             r_owner, w_owner_nx, r_rr, r_err_sticky;
   logic             w_src, w_gnt_valid, w_ar_hs, w_dst, w_r_hs;
   logic [1:0]       w_elig, w_full, w_inc, w_dec, w_uflow;
   assign w_mar[0] = i_icache_mar;
   assign w_mar[1] = i_dcache_mar;
   assign w_mr[0]  = i_icache_mr;
   assign w_mr[1]  = i_dcache_mr;
   assign w_dst    = i_mem_sr.id[ID_WIDTH-1];
   assign w_r_hs   = i_mem_sr.valid & o_mem_mr.ready;
   assign w_ar_hs  = w_gnt_valid & i_mem_sar.ready & !rst;
   for (genvar i = 0; i < 2; i++) begin : g_src
      assign w_elig[i] = w_mar[i].valid & !w_full[i];
      assign w_inc[i]  = w_ar_hs & (w_src == 1'(i));
      assign w_dec[i]  = w_r_hs & i_mem_sr.last & (w_dst == 1'(i));
      outstanding_ctr #(.MAX(MAX_OUTSTANDING)) u_ctr (
         .clk         (clk),
         .rst         (rst),
         .i_inc       (w_inc[i]),
         .i_dec       (w_dec[i]),
         .o_cnt       (w_cnt[i]),
         .o_full      (w_full[i]),
         .o_underflow (w_uflow[i])
      );
   end
   // state, locked owner, round-robin pointer and sticky protocol-error flag
   always_ff @(posedge clk)
      if (rst) begin
         r_state      <= IDLE;
         r_owner      <= ARB_SRC_ICACHE;
         r_rr         <= ARB_SRC_ICACHE;
         r_err_sticky <= 1'b0;
      end else begin
         r_state      <= w_state_nx;
         r_owner      <= w_owner_nx;
         if (w_ar_hs) r_rr <= ~w_src;
         r_err_sticky <= r_err_sticky | (w_r_hs && w_cnt[w_dst] == '0) | |w_uflow;
      end
   // lock onto a grant memory did not take so AR stays stable until accepted
   always_comb begin
      w_state_nx = r_state;
      w_owner_nx = r_owner;
      if (r_state == IDLE && w_gnt_valid && !i_mem_sar.ready) begin
         w_state_nx = LOCK;
         w_owner_nx = w_src;
      end else if (r_state == LOCK && w_ar_hs) w_state_nx = IDLE;
   end
   // grant: owner while locked, otherwise the eligible source with rr breaking ties
   always_comb begin
      w_src       = r_state == LOCK ? r_owner : &w_elig ? r_rr : w_elig[1];
      w_gnt_valid = r_state == LOCK ? w_mar[r_owner].valid : |w_elig;
   end
   // AR muxing with source tag in the id MSB, R routing by id MSB; everything masked in reset
   always_comb begin
      o_mem_mar                     = w_mar[w_src];
      o_mem_mar.id                  = tag_id(w_src, w_mar[w_src].id);
      o_mem_mar.valid               = w_gnt_valid & !rst;
      o_icache_sar.ready            = w_ar_hs & (w_src == ARB_SRC_ICACHE);
      o_dcache_sar.ready            = w_ar_hs & (w_src == ARB_SRC_DCACHE);
      o_icache_sr                   = i_mem_sr;
      o_icache_sr.id[ID_WIDTH-1]    = 1'b0;
      o_icache_sr.valid             = i_mem_sr.valid & !rst & (w_dst == ARB_SRC_ICACHE);
      o_dcache_sr                   = i_mem_sr;
      o_dcache_sr.id[ID_WIDTH-1]    = 1'b0;
      o_dcache_sr.valid             = i_mem_sr.valid & !rst & (w_dst == ARB_SRC_DCACHE);
      o_mem_mr.ready                = w_mr[w_dst].ready & !rst;
   end
`ifdef AXI_RD_ARB_PERF_EN
   logic [31:0] r_perf_gi, r_perf_gd, r_perf_st;
   // free-running grant and AR stall counters, wrapping at 2^32
   always_ff @(posedge clk)
      if (rst) begin
         r_perf_gi <= '0;
         r_perf_gd <= '0;
         r_perf_st <= '0;
      end else begin
         r_perf_gi <= r_perf_gi + 32'(w_inc[0]);
         r_perf_gd <= r_perf_gd + 32'(w_inc[1]);
         r_perf_st <= r_perf_st + 32'(o_mem_mar.valid & !i_mem_sar.ready);
      end
   assign o_perf_grant_icache = r_perf_gi;
   assign o_perf_grant_dcache = r_perf_gd;
   assign o_perf_ar_stall     = r_perf_st;
`endif
endmodule

// File: tb/tb_axi_read_arbiter.sv
// tb_axi_read_arbiter: randomized traffic against a per-cycle behavioural model of the read arbiter
module tb_axi_read_arbiter;
   import axi_read_arbiter_pkg::*;
   localparam int MAXO = 4;
   logic  clk = 1'b0;
   logic  rst;
   AxiMAR ic_mar, dc_mar, mem_mar;
   AxiSAR ic_sar, dc_sar, mem_sar;
   AxiMR  ic_mr, dc_mr, mem_mr;
   AxiSR  ic_sr, dc_sr, mem_sr;
   int    n_vec = 0;
   int    n_miss = 0;
   int    m_out [2];
   int    m_held;
   logic  m_rr;
   logic        rv [2];
   logic [2:0]  rid [2];
   logic [31:0] raddr [2];
   logic [7:0]  rlen [2];
   logic        acc [2];
   logic        rrdy [2];
   axi_read_arbiter #(.ID_WIDTH(4), .MAX_OUTSTANDING(MAXO)) dut (
      .clk          (clk),
      .rst          (rst),
      .i_icache_mar (ic_mar),
      .o_icache_sar (ic_sar),
      .i_icache_mr  (ic_mr),
      .o_icache_sr  (ic_sr),
      .i_dcache_mar (dc_mar),
      .o_dcache_sar (dc_sar),
      .i_dcache_mr  (dc_mr),
      .o_dcache_sr  (dc_sr),
      .o_mem_mar    (mem_mar),
      .i_mem_sar    (mem_sar),
      .o_mem_mr     (mem_mr),
      .i_mem_sr     (mem_sr)
   );
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
      end
   endtask
   function automatic AxiMAR mk_mar(input logic v, input logic [2:0] id, input logic [31:0] a, input logic [7:0] l);
      AxiMAR m;
      m = '0;
      m.valid = v;
      m.id = {1'b0, id};
      m.addr = a;
      m.len = l;
      m.size = 3'd3;
      m.burst = 2'd1;
      return m;
   endfunction
   initial begin
      logic elig [2];
      logic g, gv, exp_mv, mrdy, dst;
      int   d [2];
      rst = 1'b1;
      ic_mar = '0; dc_mar = '0; ic_mr = '0; dc_mr = '0; mem_sar = '0; mem_sr = '0;
      for (int s = 0; s < 2; s++) begin
         m_out[s] = 0; rv[s] = 1'b0; acc[s] = 1'b0; rid[s] = '0; raddr[s] = '0; rlen[s] = '0; rrdy[s] = 1'b0;
      end
      m_held = -1;
      m_rr = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      #1;
      chk("rst_mar_valid", 64'(mem_mar.valid), 64'(0));
      chk("rst_mem_rready", 64'(mem_mr.ready), 64'(0));
      for (int cyc = 0; cyc < 3000; cyc++) begin
         @(negedge clk);
         rst = (cyc % 700) == 699;
         for (int s = 0; s < 2; s++) begin
            if (!rv[s] || acc[s]) begin
               rv[s] = cyc < 2 ? 1'b1 : $urandom_range(0, 99) < 50;
               rid[s] = 3'($urandom);
               raddr[s] = $urandom;
               rlen[s] = 8'($urandom);
            end
            rrdy[s] = $urandom_range(0, 99) < 70;
         end
         mrdy = cyc < 2 ? 1'b1 : $urandom_range(0, 99) < 55;
         ic_mar = mk_mar(rv[0], rid[0], raddr[0], rlen[0]);
         dc_mar = mk_mar(rv[1], rid[1], raddr[1], rlen[1]);
         ic_mr.ready = rrdy[0];
         dc_mr.ready = rrdy[1];
         mem_sar.ready = mrdy;
         dst = (m_out[0] > 0 && m_out[1] > 0) ? 1'($urandom_range(0, 1)) : m_out[1] > 0;
         mem_sr.valid = (m_out[0] > 0 || m_out[1] > 0) && $urandom_range(0, 99) < 45;
         mem_sr.id = {dst, 3'($urandom)};
         mem_sr.data = {$urandom, $urandom};
         mem_sr.resp = 2'($urandom);
         mem_sr.last = $urandom_range(0, 1);
         #1;
         for (int s = 0; s < 2; s++) elig[s] = rv[s] && m_out[s] < MAXO;
         if (m_held >= 0) begin
            g = 1'(m_held);
            gv = rv[g];
         end else begin
            gv = elig[0] || elig[1];
            g = (elig[0] && elig[1]) ? m_rr : elig[1];
         end
         exp_mv = !rst && gv;
         for (int s = 0; s < 2; s++) acc[s] = exp_mv && g == 1'(s) && mrdy;
         chk("mar_valid", 64'(mem_mar.valid), 64'(exp_mv));
         if (exp_mv) begin
            chk("mar_id", 64'(mem_mar.id), 64'({g, rid[g]}));
            chk("mar_addr", 64'(mem_mar.addr), 64'(raddr[g]));
            chk("mar_len", 64'(mem_mar.len), 64'(rlen[g]));
         end
         chk("ic_ar_ready", 64'(ic_sar.ready), 64'(acc[0]));
         chk("dc_ar_ready", 64'(dc_sar.ready), 64'(acc[1]));
         chk("ic_r_valid", 64'(ic_sr.valid), 64'(!rst && mem_sr.valid && !dst));
         chk("dc_r_valid", 64'(dc_sr.valid), 64'(!rst && mem_sr.valid && dst));
         chk("mem_r_ready", 64'(mem_mr.ready), 64'(!rst && rrdy[dst]));
         if (!rst && mem_sr.valid) begin
            chk("r_id", dst ? 64'(dc_sr.id) : 64'(ic_sr.id), 64'({1'b0, mem_sr.id[2:0]}));
            chk("r_data", dst ? dc_sr.data : ic_sr.data, mem_sr.data);
            chk("r_last", dst ? 64'(dc_sr.last) : 64'(ic_sr.last), 64'(mem_sr.last));
         end
         @(posedge clk);
         if (rst) begin
            m_out[0] = 0; m_out[1] = 0; m_held = -1; m_rr = 1'b0;
         end else begin
            d[0] = 0; d[1] = 0;
            if (gv && mrdy) begin
               d[g]++;
               m_rr = ~g;
               m_held = -1;
            end else if (gv) m_held = int'(g);
            if (mem_sr.valid && rrdy[dst] && mem_sr.last) d[dst]--;
            for (int s = 0; s < 2; s++) begin
               m_out[s] += d[s];
               if (m_out[s] < 0) m_out[s] = 0;
               if (m_out[s] > MAXO) m_out[s] = MAXO;
            end
         end
      end
      #1;
      chk("no_err_sticky", 64'(dut.r_err_sticky), 64'(0));
      @(negedge clk);
      rst = 1'b1;
      ic_mar = '0; dc_mar = '0; mem_sr = '0;
      @(negedge clk);
      rst = 1'b0;
      ic_mr.ready = 1'b1;
      mem_sr.valid = 1'b1;
      mem_sr.id = 4'h1;
      mem_sr.last = 1'b1;
      #1;
      chk("orphan_routed", 64'(ic_sr.valid), 64'(1));
      chk("orphan_rready", 64'(mem_mr.ready), 64'(1));
      @(posedge clk);
      #1;
      chk("err_sticky", 64'(dut.r_err_sticky), 64'(1));
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end
endmodule
